// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result bundle between a requester and seq_divider.
// Requester -> divider: start, dividend, divisor.
// Divider -> requester: busy, done, quotient, remainder, div_zero.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;
    modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div_zero);
    modport slave  (input start, dividend, divisor, output busy, done, quotient, remainder, div_zero);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider producing one quotient bit per clock.
// Ports: clk; rst_n (asynchronous, active-low); bus (seq_divider_if.slave) carrying
//   start/dividend/divisor in and busy/done/quotient/remainder/div_zero out.
// Option: SEQ_DIVIDER_DIV_ZERO_EN makes a zero divisor skip straight to DONE with
//   div_zero=1; without it a zero divisor runs the full loop and div_zero stays 0.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo, r_div, r_quotient, r_remainder;
    logic [CW-1:0]    r_cnt;
    logic             r_div_zero;
    logic             w_accept, w_last, w_zero_skip, w_ge;
    logic [WIDTH:0]   w_rem_sh, w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    assign w_accept = r_state == IDLE && bus.start;
    assign w_last   = r_state == RUN && r_cnt == CW'(WIDTH - 1);
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
    assign w_zero_skip = w_accept && bus.divisor == '0;
`else
    assign w_zero_skip = 1'b0;
`endif
    // restoring step: the quotient register MSB shifts into the partial remainder
    assign w_rem_sh = (r_rem << 1) | (WIDTH + 1)'(r_quo[WIDTH-1]);
    assign w_ge     = w_rem_sh >= {1'b0, r_div};
    assign w_rem_nx = w_ge ? w_rem_sh - {1'b0, r_div} : w_rem_sh;
    assign w_quo_nx = (r_quo << 1) | WIDTH'(w_ge);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state == IDLE ? (bus.start ? (w_zero_skip ? DONE : RUN) : IDLE) :
                 r_state == RUN  ? (w_last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else if (w_accept) begin
            r_rem      <= '0;
            r_quo      <= bus.dividend;
            r_div      <= bus.divisor;
            r_cnt      <= '0;
            r_div_zero <= w_zero_skip;
            if (w_zero_skip) begin
                r_quotient  <= '1;
                r_remainder <= bus.dividend;
            end
        end else if (r_state == RUN) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_quotient  <= w_quo_nx;
                r_remainder <= w_rem_nx[WIDTH-1:0];
            end
        end
    end
    assign bus.busy      = r_state == RUN;
    assign bus.done      = r_state == DONE;
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.div_zero  = r_div_zero;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider, directed cases plus parallel random lanes.
`timescale 1ns/1ps
module tb_seq_divider;
    localparam int W        = 32;
    localparam int LANES    = 8;
    localparam int PER_LANE = 1250;
    localparam int LIMIT    = 100;
`ifdef SEQ_DIVIDER_DIV_ZERO_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif
    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    bit               rand_go = 1'b0;
    logic [LANES-1:0] lane_fin;
    int               n_tests = 0;
    int               n_fail = 0;
    exp_t             sb[$];

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(W)) bus ();
    seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] dd, input logic [W-1:0] dv);
        exp_t e;
        e.q   = (dv == 0) ? {W{1'b1}} : dd / dv;
        e.r   = (dv == 0) ? dd : dd % dv;
        e.dz  = DZ_EN && dv == 0;
        e.lat = e.dz ? 1 : W + 1;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_divisor();
        int p = $urandom_range(99);
        return p < 5 ? '0 : p < 10 ? W'(1) : W'($urandom >> $urandom_range(31));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] dd, input logic [W-1:0] dv);
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = dv;
        sb.push_back(model(dd, dv));
    endtask

    // n counts edges from the accepting edge up to the sample where done is seen
    task automatic wait_done(input bit hold, input bit disturb, output int n, output int nb);
        n  = 0;
        nb = 0;
        do begin
            step();
            n++;
            nb += int'(bus.busy);
            if (!hold) bus.start = disturb && (n % 5 == 0);
            if (disturb) begin
                bus.dividend = $urandom;
                bus.divisor  = $urandom;
            end
        end while (!bus.done && n < LIMIT);
    endtask

    task automatic score(input string tag, input int n, input int nb);
        exp_t e;
        if (sb.size() == 0) check({tag, " sb"}, 0, 1);
        else begin
            e = sb.pop_front();
            check({tag, " lat"}, n, e.lat);
            check({tag, " busy"}, nb, e.lat - 1);
            check({tag, " q"}, bus.quotient, e.q);
            check({tag, " r"}, bus.remainder, e.r);
            check({tag, " dz"}, bus.div_zero, e.dz);
        end
    endtask

    for (genvar g = 0; g < LANES; g++) begin : lane
        seq_divider_if #(.WIDTH(W)) rif ();
        seq_divider #(.WIDTH(W)) rdut (.clk(clk), .rst_n(rst_n), .bus(rif.slave));
        exp_t lq[$];
        bit   fin = 1'b0;
        assign lane_fin[g] = fin;
        initial begin
            exp_t         e;
            logic [W-1:0] dd, dv;
            int           n;
            rif.start    = 1'b0;
            rif.dividend = '0;
            rif.divisor  = '0;
            wait (rand_go);
            for (int i = 0; i < PER_LANE; i++) begin
                dd           = $urandom >> $urandom_range(31);
                dv           = rnd_divisor();
                rif.start    = 1'b1;
                rif.dividend = dd;
                rif.divisor  = dv;
                lq.push_back(model(dd, dv));
                n = 0;
                do begin
                    step();
                    n++;
                    rif.start = 1'b0;
                end while (!rif.done && n < LIMIT);
                e = lq.pop_front();
                check($sformatf("lane%0d lat", g), n, e.lat);
                check($sformatf("lane%0d q %0h/%0h", g, dd, dv), rif.quotient, e.q);
                check($sformatf("lane%0d r %0h/%0h", g, dd, dv), rif.remainder, e.r);
                check($sformatf("lane%0d dz", g), rif.div_zero, e.dz);
                step();
            end
            fin = 1'b1;
        end
    end

    initial begin
        int n, nb, pulses;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst q", bus.quotient, 0);
        check("rst r", bus.remainder, 0);
        check("rst dz", bus.div_zero, 0);
        rst_n = 1'b1;
        step();
        launch(100, 7);
        wait_done(0, 0, n, nb);
        score("100/7", n, nb);
        step();
        check("done pulse width", bus.done, 0);
        check("q hold after done", bus.quotient, 14);
        launch(32'hFFFF_FFFF, 1);
        wait_done(1, 0, n, nb);
        score("ffffffff/1", n, nb);
        launch(5, 9);
        step();
        check("b2b idle busy", bus.busy, 0);
        check("b2b idle done", bus.done, 0);
        check("b2b q hold", bus.quotient, 32'hFFFF_FFFF);
        wait_done(0, 0, n, nb);
        score("5/9", n, nb);
        step();
        launch(1234, 0);
        wait_done(0, 0, n, nb);
        score("1234/0", n, nb);
        step();
        launch(1000, 3);
        wait_done(0, 1, n, nb);
        score("1000/3 ignore start", n, nb);
        step();
        bus.start    = 1'b1;
        bus.dividend = 1000;
        bus.divisor  = 3;
        repeat (11) begin
            step();
            bus.start = 1'b0;
        end
        check("abort busy before rst", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort busy", bus.busy, 0);
        check("abort done", bus.done, 0);
        check("abort q", bus.quotient, 0);
        check("abort r", bus.remainder, 0);
        check("abort dz", bus.div_zero, 0);
        pulses = 0;
        repeat (3) begin
            step();
            pulses += int'(bus.done);
        end
        rst_n = 1'b1;
        repeat (40) begin
            step();
            pulses += int'(bus.done);
        end
        check("abort done pulses", pulses, 0);
        launch(50, 5);
        wait_done(0, 0, n, nb);
        score("50/5", n, nb);
        step();
        rand_go = 1'b1;
        n = 0;
        while (lane_fin !== {LANES{1'b1}} && n < 60000) begin
            step();
            n++;
        end
        check("lanes finished", 64'(lane_fin), (64'd1 << LANES) - 1);
        check("sb empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width in bits; the counter width SHALL be clog2(WIDTH)+1.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, WIDTH bits: unsigned numerator, captured when start is accepted.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: unsigned denominator, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when results become valid.
REQ-009 The block SHALL have port quotient, output, WIDTH bits: registered quotient.
REQ-010 The block SHALL have port remainder, output, WIDTH bits: registered remainder.
REQ-011 The block SHALL have port div_zero, output, 1 bit: set with done when divisor was 0.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 The FSM transitions SHALL be: IDLE->RUN on start=1; RUN->DONE after the WIDTH-th iteration; DONE->IDLE unconditionally after one cycle.
REQ-014 On an accepted start the block SHALL load the working register {rem[WIDTH:0]=0, quo=dividend}, latch divisor, clear the counter and clear div_zero.
REQ-015 Each RUN cycle SHALL perform one restoring step: shift {rem,quo} left 1; if rem >= {0,divisor} (WIDTH+1-bit compare), rem -= divisor and quo[0]=1, else quo[0]=0; counter += 1.
REQ-016 Latency: start sampled at edge 0, iterations SHALL occur at edges 1..WIDTH, and done SHALL be high in the cycle after edge WIDTH (WIDTH+1 cycles, start to done).
REQ-017 The quotient and remainder outputs SHALL update at the DONE entry edge and SHALL hold until the next accepted start.
REQ-018 start SHALL be ignored in RUN and DONE; a start held high through DONE SHALL be accepted in the following IDLE cycle.
REQ-019 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor for every divisor != 0, including dividend < divisor (quotient=0, remainder=dividend).
REQ-020 Operand input changes after acceptance SHALL have no effect on the operation in progress.

Reset
REQ-021 While rst_n=0 the block SHALL force: state=IDLE, counter=0, busy=0, done=0, div_zero=0, quotient=0, remainder=0, working register=0.
REQ-022 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-023 The block SHALL honour macro SEQ_DIVIDER_DIV_ZERO_EN: when defined, a start with divisor=0 SHALL go IDLE->DONE directly (done one cycle after acceptance) with quotient=all ones, remainder=dividend and div_zero=1.
REQ-024 When SEQ_DIVIDER_DIV_ZERO_EN is undefined, divisor=0 SHALL run the full WIDTH iterations and naturally yield quotient=all ones and remainder=dividend, and div_zero SHALL be tied to 0.

Verification
REQ-025 Bench SHALL apply 100/7 with WIDTH=32 -> done exactly 33 cycles after the start edge, quotient=14, remainder=2, busy high for 32 cycles.
REQ-026 Bench SHALL apply 0xFFFFFFFF/1 then 5/9 back-to-back (start held high) -> results Q=0xFFFFFFFF,R=0, then Q=0,R=5, with the second start accepted in the IDLE cycle following DONE.
REQ-027 Bench SHALL apply 1234/0 -> with macro: done 1 cycle later, Q=0xFFFFFFFF, R=1234, div_zero=1; without macro: done at 33 cycles, same Q/R, div_zero=0.
REQ-028 Bench SHALL start 1000/3 and pulse start plus new operands during RUN -> they are ignored and the result is Q=333, R=1.
REQ-029 Bench SHALL drive rst_n low at iteration 10 of 1000/3 -> all outputs 0 and no done pulse; then 50/5 -> Q=10, R=0 at 33 cycles.
REQ-030 Bench SHALL run 10,000 random operand pairs, checked against a reference model, with divisor=0 and divisor=1 forced at 5% each.
